// File: rtl/sbus_arbiter_if.sv
// sbus memory-port interface: a requester drives en/we/size/addr/data_w,
// and the responder returns data_r/stall.
interface sbus;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_w;
  logic [31:0] data_r;
  logic        stall;

  modport master (output en, we, size, addr, data_w, input data_r, stall);
  modport slave  (input en, we, size, addr, data_w, output data_r, stall);
endinterface

// File: rtl/sbus_arbiter.sv
// Two-to-one sbus arbiter: dbus has priority, and a stalled transaction keeps its grant.
// Optional fetch starvation guard enabled by `define SBUS_ARB_STARVE_GUARD_EN.
module sbus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  sbus.slave   ibus,
  sbus.slave   dbus,
  sbus.master  mbus
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t state, state_nxt;
  logic   sel_i, sel_d;
  logic   tripped;
  logic   i_done, d_done;

  assign i_done = sel_i & ~mbus.stall;
  assign d_done = sel_d & ~mbus.stall;

`ifdef SBUS_ARB_STARVE_GUARD_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  // Counts dbus completions that fetch had to wait through.
  always_ff @(posedge clk) begin
    if (!resetn)                 starve_cnt <= '0;
    else if (!ibus.en || i_done) starve_cnt <= '0;
    else if (d_done && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 4'd1;
  end

  assign tripped = (starve_cnt == LIMIT);
`else
  assign tripped = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    sel_i     = 1'b0;
    sel_d     = 1'b0;
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (dbus.en && !(ibus.en && tripped)) sel_d = 1'b1;
        else if (ibus.en)                     sel_i = 1'b1;
      end
      LOCK_I:  sel_i = ibus.en;
      LOCK_D:  sel_d = dbus.en;
      default: ;
    endcase
    // Reset masks any grant so mbus goes quiet and both masters see stall=en.
    if (!resetn) begin
      sel_i = 1'b0;
      sel_d = 1'b0;
    end
    // Owner dropping en (abort) or completing falls back to IDLE.
    if (sel_i && mbus.stall)      state_nxt = LOCK_I;
    else if (sel_d && mbus.stall) state_nxt = LOCK_D;
  end

  assign mbus.en     = sel_i | sel_d;
  assign mbus.we     = (sel_i & ibus.we) | (sel_d & dbus.we);
  assign mbus.size   = sel_i ? ibus.size   : sel_d ? dbus.size   : 2'b0;
  assign mbus.addr   = sel_i ? ibus.addr   : sel_d ? dbus.addr   : 32'b0;
  assign mbus.data_w = sel_i ? ibus.data_w : sel_d ? dbus.data_w : 32'b0;

  // Non-owners see stall=en: waiting requesters hold, idle ones stay free.
  assign ibus.stall  = sel_i ? mbus.stall  : ibus.en;
  assign dbus.stall  = sel_d ? mbus.stall  : dbus.en;
  assign ibus.data_r = sel_i ? mbus.data_r : 32'b0;
  assign dbus.data_r = sel_d ? mbus.data_r : 32'b0;

endmodule

// File: doc/sbus_arbiter.md
# sbus_arbiter

Two-to-one arbiter sharing a single `sbus` memory port between the instruction-fetch master and the data-access master of the pipeline. It sits between the core's fetch/memory stages and the cache/bridge slave. It forwards the winning request unmodified, locks the grant for the whole of a stalled transaction, and stalls the losing master. Data requests have priority; an optional starvation guard bounds how long fetch can be locked out.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: number of consecutive completed dbus grants, taken while ibus waits, after which ibus wins the next contested arbitration. Legal range is 1..15. Used only with `SBUS_ARB_STARVE_GUARD_EN`.

Ports:
- `clk`  in  1  — the single clock; all state updates on the rising edge.
- `resetn`  in  1  — synchronous, active-low reset.
- `ibus`  sbus.slave  iface  — instruction-fetch requester (en, we, size[1:0], addr[31:0], data_w[31:0] in; data_r[31:0], stall out).
- `dbus`  sbus.slave  iface  — data-access requester, same fields.
- `mbus`  sbus.master  iface  — shared downstream port to the cache/bridge.

## Operation
- **sbus protocol.**
  - A master asserts `en` with its fields and holds them stable while `stall`=1.
  - A transaction completes in the cycle where `en`=1 and `stall`=0; `data_r` is valid in that cycle.
- **States:** IDLE, LOCK_I, LOCK_D (2-bit register).
- **IDLE.**
  - The winner is chosen combinationally from this cycle's `en` bits: dbus if `dbus.en`, else ibus if `ibus.en`, else none.
  - Guard override: if both request and the guard is tripped, ibus wins.
  - All winner fields are forwarded to `mbus` in the same cycle.
  - If `mbus.stall`=0, the transaction completes and the state stays IDLE.
  - If `mbus.stall`=1, the next state is LOCK_I or LOCK_D for the winner.
- **LOCK_x.**
  - `mbus` is driven from owner x only, whatever the other master's `en` is.
  - Leave to IDLE on the cycle the owner completes (`mbus.stall`=0), or when the owner drops `en` (abort).
  - On abort, `mbus.en` is 0 in that same cycle.
- **Stall routing.**
  - Owner: `stall` = `mbus.stall`, `data_r` = `mbus.data_r`.
  - Non-owner with `en`=1: `stall`=1, `data_r`=0.
  - Any master with `en`=0: `stall`=0, `data_r`=0.
- **No request.** `mbus.en`=0 and all other `mbus` outputs are 0.
- **Back-to-back.** A completion in cycle N re-arbitrates in cycle N+1. The same master may win again.

## Timing
- Zero added latency: request-to-`mbus` and `mbus.stall`/`data_r`-to-master are combinational paths.
- Grant changes only at IDLE arbitration points and never inside a locked transaction.
- **Reset** (`resetn`=0 at an edge): state goes to IDLE and the starvation counter to 0.
  - While `resetn`=0, `mbus.en` is forced to 0, so `mbus` outputs read 0.
  - Each master's `stall` equals its own `en`, and `data_r`=0.
- **Reset mid-LOCK:** the lock is dropped at that edge. After reset releases, the first cycle is a fresh IDLE arbitration.
- **Simultaneous events:**
  - Both masters requesting in IDLE: dbus wins, unless the guard is tripped.
  - Owner completion plus a new request from the other master in the same cycle: the other master is served from the next cycle.

## Configuration
- Macro `SBUS_ARB_STARVE_GUARD_EN`.
- **Defined:**
  - A counter of width 4 increments on each completed dbus transaction in a cycle where `ibus.en`=1.
  - It saturates at `STARVE_LIMIT` and clears to 0 on an ibus completion or any cycle with `ibus.en`=0.
  - "Tripped" means the counter equals `STARVE_LIMIT`.
- **Undefined:** no counter exists, and dbus always wins contested IDLE arbitration (strict priority).

## Test plan
- **Single fetch:** `ibus.en`=1, addr=0xBFC00000, `mbus.stall`=0.
  - Expect `mbus.addr`=0xBFC00000 in the same cycle and `ibus.data_r`=`mbus.data_r`.
  - Expect `ibus.stall`=0 and the state to stay IDLE.
- **Contention with lock:** both request; `mbus.stall`=1 for 3 cycles, then 0.
  - Expect dbus forwarded for 4 cycles and `ibus.stall`=1 throughout.
  - Expect ibus forwarded in cycle 5.
- **Lock held against priority:** ibus is locked with `mbus.stall`=1 when `dbus.en` rises.
  - Expect `mbus` to keep carrying the ibus addr and `dbus.stall`=1 until the ibus completion.
  - Expect dbus to win the next cycle.
- **Abort and reset:**
  - Owner dbus drops `en` while in LOCK_D: expect `mbus.en`=0 that cycle and IDLE next.
  - Assert `resetn`=0 during LOCK_I: expect IDLE after the edge and `ibus.stall`=`ibus.en` while in reset.
- **Guard (macro defined, STARVE_LIMIT=4):** both requesting continuously, `mbus.stall`=0 every cycle.
  - Expect the grant sequence D, D, D, D, I, D, D, D, D, I.
  - With the macro undefined: expect D on every cycle.
